// File: rtl/sum_div_unit.sv
// sum_div_unit
//   Consumes the two captured results of the running-sum generator.
//   On start it captures in_A (divisor/subtrahend) and in_B
//   (dividend/minuend), then produces:
//     diff = (in_B - in_A) mod 2^WIDTH
//     quot = floor(in_B / in_A), rem = in_B mod in_A
//   The division uses restoring subtraction, one compare per cycle.
//   Results are held until the next done or reset.
//
// Ports
//   clk      system clock, rising edge
//   reset    synchronous, active-high
//   start    request, sampled only in IDLE
//   in_A     divisor / subtrahend
//   in_B     dividend / minuend
//   busy     high while not in IDLE
//   done     one-cycle pulse, results valid in this cycle
//   diff     difference result
//   quot     quotient (all ones on divide-by-zero)
//   rem      remainder (dividend on divide-by-zero)
//   div_err  only with DIVZERO_ERR_EN: 1 if the captured divisor was 0
//
// Optional feature macro: DIVZERO_ERR_EN
//
// state | meaning
// IDLE  | waiting for start
// SUB   | one restoring-subtraction step per cycle
// DONE  | results loaded, done pulse
module sum_div_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
`ifdef DIVZERO_ERR_EN
  ,
  output logic             div_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] dif_r;

  logic dvs_zero;
  logic can_sub;

  assign dvs_zero = (dvs == '0);
  assign can_sub  = (rem_r >= dvs);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = SUB;
      end
      SUB: begin
        if (dvs_zero || !can_sub) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvs    <= '0;
      rem_r  <= '0;
      quot_r <= '0;
      dif_r  <= '0;
      diff   <= '0;
      quot   <= '0;
      rem    <= '0;
`ifdef DIVZERO_ERR_EN
      div_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvs    <= in_A;
            rem_r  <= in_B;
            dif_r  <= in_B - in_A;
            quot_r <= '0;
          end
        end
        SUB: begin
          if (dvs_zero) begin
            // rem_r still holds the untouched dividend here
            diff <= dif_r;
            quot <= '1;
            rem  <= rem_r;
`ifdef DIVZERO_ERR_EN
            div_err <= 1'b1;
`endif
          end else if (can_sub) begin
            rem_r  <= rem_r - dvs;
            quot_r <= quot_r + 1'b1;
          end else begin
            diff <= dif_r;
            quot <= quot_r;
            rem  <= rem_r;
`ifdef DIVZERO_ERR_EN
            div_err <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sum_div_unit.md
Name: sum_div_unit

Overview:
- Downstream consumer of the running-sum generator's two captured results.
- port_A (sum 1..10 = 55) feeds in_A; port_B (sum 1..20 = 210) feeds in_B.
- On a start pulse it captures both values, then produces:
  - the difference in_B - in_A, which is the partial sum 11..20;
  - the integer quotient and remainder of in_B / in_A, by sequential restoring subtraction.
- Results are held for downstream display/check logic.

Parameters:
- WIDTH, 8, data width of inputs and all result outputs.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- in_A  input  WIDTH  divisor / subtrahend (from generator port_A)
- in_B  input  WIDTH  dividend / minuend (from generator port_B)
- busy  output  1  high while not in IDLE
- done  output  1  one-cycle pulse; results valid and updated in this cycle
- diff  output  WIDTH  (in_B - in_A) mod 2^WIDTH
- quot  output  WIDTH  floor(in_B / in_A)
- rem  output  WIDTH  in_B mod in_A

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - busy, done, diff, quot and rem = 0.
  - Internal registers dvs, rem_r, quot_r and dif_r = 0.
- Reset has priority over every other event, including start in the same cycle.
- Reset mid-operation aborts the operation: back to IDLE, no done pulse, outputs cleared.
- IDLE:
  - busy = 0.
  - If start = 1: capture dvs <= in_A, rem_r <= in_B, dif_r <= in_B - in_A (wraps), quot_r <= 0; next state SUB.
  - Otherwise stay in IDLE.
- SUB (one compare per cycle):
  - if dvs == 0 -> DONE (divide-by-zero path);
  - else if rem_r >= dvs -> rem_r <= rem_r - dvs, quot_r <= quot_r + 1, stay in SUB;
  - else -> DONE.
- Result load on the edge leaving SUB:
  - diff <= dif_r, quot <= quot_r, rem <= rem_r.
  - Divide-by-zero instead loads quot <= all ones and rem <= captured dividend.
- DONE:
  - done = 1 and busy = 1 for exactly one cycle.
  - The new results are visible in this same cycle; next state is IDLE.
- Latency: with q = quotient and start sampled in cycle T, done is high in cycle T + q + 2.
  - q = 0 and divide-by-zero: 2 cycles.
  - Worst case (in_A=1, in_B=255 at WIDTH 8): 257 cycles.
- quot_r cannot overflow because q <= 2^WIDTH - 1 whenever dvs >= 1.
- start while busy (SUB or DONE) is ignored and not queued.
- in_A and in_B may change freely after the capture cycle without affecting the operation.
- diff, quot and rem hold their values until the next done or reset.
- Unsigned arithmetic only.

Optional Feature:
- Macro: DIVZERO_ERR_EN.
- Defined:
  - Adds port div_err (output, 1 bit, reset 0).
  - div_err is loaded together with the results: 1 if the captured divisor was 0, else 0.
  - div_err holds until the next done or reset.
- Undefined:
  - No div_err port.
  - Divide-by-zero still yields quot = all ones and rem = dividend, with 2-cycle latency.

Test Plan:
- in_A=55, in_B=210, start 1-cycle pulse at T -> done only at T+5; quot=3, rem=45, diff=155; busy high T+1..T+5.
- in_A=0, in_B=210, start -> done at T+2; quot=255, rem=210, diff=210; div_err=1 if DIVZERO_ERR_EN (0 on the next run with nonzero divisor).
- in_A=1, in_B=255, start -> done at T+257; quot=255, rem=0, diff=254.
- in_A=200, in_B=55, start -> done at T+2; quot=0, rem=55, diff=111 (wrap).
- Start 55/210, re-pulse start at T+2 with in_A=5 -> ignored, results still 3/45/155.
  - Then reset at T+3 of a new run -> busy=0, done never pulses, outputs 0.
  - Then a fresh start completes normally.
- reset and start asserted in the same cycle -> stays IDLE, busy=0, no capture.
